mem_request_arbiter: RTL and testbench
======================================

// Module: mem_request_arbiter
// PURPOSE
//  Shares the single RAM port between instruction fetch (pc) and data load/store (control/ALU).
//  Accepts one request at a time and drives the RAM for RAM_LATENCY cycles.
//  Returns the loaded word with a one-cycle i_ready / d_ready pulse, which stalls the core.
//  Sits between the core (pc, control, writeToReg) and the RAM interface.
// PARAMETERS
//  ADDR_W       32  address width of all ports
//  DATA_W       32  data width of all ports
//  RAM_LATENCY  2   non-busy RAM cycles per access; legal range >= 1
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       synchronous, active-high reset
//  i_req      in   1       instruction fetch request; held until i_ready
//  i_addr     in   ADDR_W  fetch address (pc)
//  i_data     out  DATA_W  fetched instruction, registered
//  i_ready    out  1       one-cycle pulse: fetch complete, i_data valid
//  d_ren      in   1       data read request; held until d_ready
//  d_wen      in   1       data write request; held until d_ready
//  d_addr     in   ADDR_W  data address (aluOut)
//  d_store    in   DATA_W  store data (regData2)
//  d_load     out  DATA_W  loaded data word, registered (memload)
//  d_ready    out  1       one-cycle pulse: data access complete
//  ram_addr   out  ADDR_W  RAM address
//  ram_store  out  DATA_W  RAM write data
//  ram_ren    out  1       RAM read enable
//  ram_wen    out  1       RAM write enable
//  ram_load   in   DATA_W  RAM read data, valid in the final access cycle
//  ram_busy   in   1       RAM stall; the access cycle is not counted while high
// BEHAVIOUR
//  Reset (sync, high): state=IDLE, cnt=0, last_grant=INSTR.
//   All outputs are 0: i_data, d_load, ready pulses, ram_* buses and enables.
//  FSM states: IDLE, IACC, DACC, RESP.
//  IDLE:
//   - A request is pending when d_ren|d_wen or i_req is high.
//   - If both ports are pending, grant the port NOT equal to last_grant.
//     First contention after reset therefore goes to data.
//   - If one port is pending, grant it.
//   - On grant:
//     - latch addr (and d_store, plus op = write if d_wen else read);
//     - set last_grant; cnt=0; next state IACC or DACC.
//   - d_ren & d_wen both high = write; the read is not performed.
//   - ram_ren=ram_wen=0 while in IDLE.
//  IACC / DACC:
//   - ram_addr = latched addr.
//   - IACC: ram_ren=1.
//   - DACC read: ram_ren=1. DACC write: ram_wen=1, ram_store = latched d_store.
//   - Changes on request inputs are ignored; values are latched.
//   - cnt += 1 on every cycle with ram_busy=0.
//   - When ram_busy=0 and cnt==RAM_LATENCY-1 (the final access cycle):
//     - read: capture ram_load into i_data or d_load;
//     - next state RESP.
//   - ram_busy=1 freezes cnt and holds all ram_* outputs stable.
//  RESP:
//   - Exactly one of i_ready / d_ready is 1 for this single cycle; ram enables are 0.
//   - Next state IDLE.
//   - A request still high in IDLE is treated as a NEW transaction.
//     Requesters drop req in the cycle after ready.
//  Latency: request seen in IDLE at cycle 0.
//   - With no busy cycles, ready is high at cycle RAM_LATENCY+1.
//   - Example: cycle 3 for RAM_LATENCY=2.
//  i_data / d_load hold their value until the next read on that port.
//   A write never changes d_load.
//  Reset mid-access: abort immediately at the next edge.
//   - Enables drop to 0 and no ready pulse is issued.
//   - Captured data is cleared.
//  cnt width is $clog2(RAM_LATENCY+1). Wrap is impossible because cnt clears on every grant.
// TESTING
//  1. reset, i_req=1, i_addr=0x0000_0010, ram_load=0x0050_0093, L=2
//     -> ram_ren=1 at cycles 1-2; i_ready=1 at cycle 3; i_data=0x0050_0093.
//  2. d_wen=1, d_addr=0x100, d_store=0xDEAD_BEEF
//     -> ram_wen=1, ram_addr=0x100, ram_store=0xDEADBEEF for 2 cycles;
//        d_ready pulse; d_load unchanged.
//  3. i_req and d_ren both high right after reset
//     -> data served first; fetch served next with no idle gap beyond RESP;
//        then, both high again -> data first, since last_grant alternates.
//  4. ram_busy=1 for 3 cycles mid DACC read
//     -> ram_* outputs stable; d_ready delayed by exactly 3 cycles (cycle 6).
//  5. reset asserted in IACC cycle 1
//     -> next cycle: ram_ren=0, i_ready never pulses, state IDLE, i_data=0.
//  6. d_ren & d_wen both high -> write only: ram_wen=1, ram_ren=0 throughout.

Source files
------------

// File: rtl/mem_request_arbiter.sv
// Shares one RAM port between instruction fetch and data load/store.
// One access at a time; alternates grants under contention; one-cycle ready pulse per access.
module mem_request_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RAM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_ready,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_store,
  output logic [DATA_W-1:0] d_load,
  output logic              d_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  output logic              ram_ren,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_load,
  input  logic              ram_busy
);

  localparam int CNT_W = $clog2(RAM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              last_data;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic              d_pend;
  logic              grant_d;

  assign d_pend  = d_ren | d_wen;
  // With both ports pending, the port that was not served last wins.
  assign grant_d = d_pend & (~i_req | ~last_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_data <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      store_q   <= '0;
      i_data    <= '0;
      d_load    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            addr_q    <= d_addr;
            store_q   <= d_store;
            wr_q      <= d_wen;
            last_data <= 1'b1;
            cnt       <= '0;
            state     <= DACC;
          end else if (i_req) begin
            addr_q    <= i_addr;
            wr_q      <= 1'b0;
            last_data <= 1'b0;
            cnt       <= '0;
            state     <= IACC;
          end
        end
        IACC, DACC: begin
          // A busy RAM cycle does not count toward the access length.
          if (!ram_busy) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              if (state == IACC)
                i_data <= ram_load;
              else if (!wr_q)
                d_load <= ram_load;
              state <= RESP;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // In RESP, last_data still identifies the port that was just served.
  assign ram_addr  = (state == IACC || state == DACC) ? addr_q : '0;
  assign ram_ren   = (state == IACC) || (state == DACC && !wr_q);
  assign ram_wen   = (state == DACC) && wr_q;
  assign ram_store = ram_wen ? store_q : '0;
  assign i_ready   = (state == RESP) && !last_data;
  assign d_ready   = (state == RESP) && last_data;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Self-checking bench for mem_request_arbiter: directed cases plus random transactions
// checked against a transaction-level model of grant order, latency and captured data.
module tb_mem_request_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_ready;
  logic        d_ren;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_store;
  logic [31:0] d_load;
  logic        d_ready;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_load;
  logic        ram_busy;

  int num_asserts = 0;
  int num_fail    = 0;

  logic [31:0] exp_i_data;
  logic [31:0] exp_d_load;
  bit          last_data;

  mem_request_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store),
    .d_load(d_load), .d_ready(d_ready),
    .ram_addr(ram_addr), .ram_store(ram_store), .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_load(ram_load), .ram_busy(ram_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_asserts++;
    assert (obs === exp) else begin
      num_fail++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Synchronous reset pulse; checks that every output is cleared.
  task automatic doReset();
    @(posedge clk); #1;
    reset = 1'b1; i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0; ram_busy = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_i_data",    i_data,          32'h0);
    checkOutput("rst_d_load",    d_load,          32'h0);
    checkOutput("rst_ready",     32'({i_ready, d_ready}), 32'h0);
    checkOutput("rst_ram_addr",  ram_addr,        32'h0);
    checkOutput("rst_ram_store", ram_store,       32'h0);
    checkOutput("rst_ram_en",    32'({ram_ren, ram_wen}), 32'h0);
    reset      = 1'b0;
    exp_i_data = 32'h0;
    exp_d_load = 32'h0;
    last_data  = 1'b0;
  endtask

  // One complete transaction, starting with the DUT in IDLE. busy_len busy cycles are
  // inserted starting at access cycle busy_at (1..L), so they fall inside the access.
  task automatic applyStimulus(input logic iq, input logic dr, input logic dw,
                               input logic [31:0] ia, input logic [31:0] da,
                               input logic [31:0] ds, input logic [31:0] ld,
                               input int busy_at, input int busy_len);
    logic        grant_d;
    logic        is_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_store;
    int          n_acc;
    @(posedge clk); #1;
    i_req = iq; d_ren = dr; d_wen = dw;
    i_addr = ia; d_addr = da; d_store = ds;
    ram_busy = 1'b0; ram_load = $urandom;
    grant_d   = (dr | dw) && (!iq || !last_data);
    is_wr     = grant_d && dw;
    exp_addr  = grant_d ? da : ia;
    exp_store = is_wr ? ds : 32'h0;
    @(negedge clk);
    checkOutput("idle_ram_en", 32'({ram_ren, ram_wen}), 32'h0);
    checkOutput("idle_ready",  32'({i_ready, d_ready}), 32'h0);
    n_acc = L + busy_len;
    for (int k = 1; k <= n_acc; k++) begin
      @(posedge clk); #1;
      ram_busy = (busy_len > 0) && (k >= busy_at) && (k < busy_at + busy_len);
      ram_load = (k == n_acc) ? ld : $urandom;
      i_addr = $urandom; d_addr = $urandom; d_store = $urandom;
      @(negedge clk);
      checkOutput("acc_ram_addr",  ram_addr,        exp_addr);
      checkOutput("acc_ram_store", ram_store,       exp_store);
      checkOutput("acc_ram_ren",   32'(ram_ren),    32'(!is_wr));
      checkOutput("acc_ram_wen",   32'(ram_wen),    32'(is_wr));
      checkOutput("acc_ready",     32'({i_ready, d_ready}), 32'h0);
    end
    if (!is_wr) begin
      if (grant_d) exp_d_load = ld;
      else         exp_i_data = ld;
    end
    last_data = grant_d;
    @(posedge clk); #1;
    ram_busy = 1'b0;
    @(negedge clk);
    checkOutput("resp_i_ready", 32'(i_ready), 32'(!grant_d));
    checkOutput("resp_d_ready", 32'(d_ready), 32'(grant_d));
    checkOutput("resp_ram_en",  32'({ram_ren, ram_wen}), 32'h0);
    checkOutput("resp_i_data",  i_data, exp_i_data);
    checkOutput("resp_d_load",  d_load, exp_d_load);
    if (grant_d) begin
      d_ren = 1'b0; d_wen = 1'b0;
    end else begin
      i_req = 1'b0;
    end
  endtask

  initial begin
    logic iq, dr, dw;
    reset = 1'b1; i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    i_addr = '0; d_addr = '0; d_store = '0; ram_load = '0; ram_busy = 1'b0;
    exp_i_data = '0; exp_d_load = '0; last_data = 1'b0;

    doReset();

    // Instruction fetch with fixed values.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_0010, $urandom, $urandom, 32'h0050_0093, 1, 0);
    // Plain write: d_load must stay untouched.
    applyStimulus(1'b0, 1'b0, 1'b1, $urandom, 32'h0000_0100, 32'hDEAD_BEEF, $urandom, 1, 0);

    // Contention right after reset: data, then fetch, then data again.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom, 1, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, 1, 0);
    i_req = 1'b0;

    // Data read stalled three cycles mid-access.
    applyStimulus(1'b0, 1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, 2, 3);
    // Read and write together behave as a write.
    applyStimulus(1'b0, 1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 1, 0);

    // Random transactions.
    for (int n = 0; n < 40; n++) begin
      iq = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
      if (!iq && !dr && !dw) iq = 1'b1;
      applyStimulus(iq, dr, dw, $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(1, L), $urandom_range(0, 3));
      i_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
    end

    // Make sure captured data is non-zero before testing the mid-access reset.
    applyStimulus(1'b1, 1'b0, 1'b0, $urandom, $urandom, $urandom, 32'hCAFE_F00D, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, $urandom, $urandom, $urandom, 32'h1234_5678, 1, 0);

    // Reset during the first fetch access cycle aborts the access.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = $urandom;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_iacc_ren", 32'(ram_ren), 32'h1);
    @(posedge clk); #1;
    i_req = 1'b0;
    @(negedge clk);
    checkOutput("abort_ram_ren", 32'(ram_ren), 32'h0);
    checkOutput("abort_i_data",  i_data,       32'h0);
    checkOutput("abort_d_load",  d_load,       32'h0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("abort_no_ready", 32'({i_ready, d_ready}), 32'h0);
      checkOutput("abort_idle_en",  32'({ram_ren, ram_wen}), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_fail);
    $finish;
  end

endmodule
